// File: rtl/reg_bank_5b_pkg.sv
// Shared sizing and index constants for the 32 x 32-bit register bank.
package reg_bank_5b_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_W    = 5;

  localparam int unsigned ZERO_IDX = 0;
  localparam int unsigned SP_IDX   = 29;
  localparam int unsigned RA_IDX   = 31;

  typedef logic [IDX_W-1:0]    reg_idx_t;
  typedef logic [DATA_W-1:0]   reg_data_t;
  typedef logic [NUM_REGS-1:0] reg_onehot_t;

endpackage

// File: rtl/decoder5to32.sv
// Combinational 5-to-32 one-hot decoder with enable; all-zero output when disabled.
module decoder5to32
  import reg_bank_5b_pkg::*;
(
  input  logic        en,
  input  logic [4:0]  idx,
  output logic [31:0] onehot
);

  // Index is only evaluated under enable, so an unknown idx cannot leak a set bit.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_bank_5b.sv
// 32 x 32-bit register file: one synchronous write port, two combinational read ports,
// register 0 hard-wired to zero, stack pointer register reset to a non-zero value.
module reg_bank_5b #(
  parameter int unsigned SP_IDX   = reg_bank_5b_pkg::SP_IDX,
  parameter logic [31:0] SP_RESET = 32'd227
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reg_write,
  input  logic [4:0]  write_reg,
  input  logic [31:0] write_data,
  input  logic [4:0]  read_reg1,
  input  logic [4:0]  read_reg2,
  output logic [31:0] read_data1,
  output logic [31:0] read_data2
);

  import reg_bank_5b_pkg::*;

  reg_onehot_t we;
  reg_data_t   regs [NUM_REGS];

  decoder5to32 u_dec (
    .en     (reg_write),
    .idx    (write_reg),
    .onehot (we)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (we[i] && (i != ZERO_IDX)) begin
          regs[i] <= write_data;
        end
      end
    end
  end

  always_comb begin
    read_data1 = regs[read_reg1];
    read_data2 = regs[read_reg2];
  end

endmodule

// File: tb/tb_reg_bank_5b.sv
// Self-checking bench for reg_bank_5b: directed vector table, hand-written corner
// sequences and randomized traffic checked against an array model.
module tb_reg_bank_5b;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [32];

  reg_bank_5b #(.SP_IDX(29), .SP_RESET(32'd227)) dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .read_data1 (read_data1),
    .read_data2 (read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = (i == 29) ? 32'd227 : 32'd0;
  endtask

  // Advance through one rising edge, applying the architectural write rule to the model.
  task automatic edge_update();
    @(posedge clk);
    if (!reset && reg_write && write_reg != 5'd0) model[write_reg] = write_data;
    #1;
  endtask

  task automatic check_model(input string name);
    check({name, "_p1"}, read_data1, model[read_reg1]);
    check({name, "_p2"}, read_data2, model[read_reg2]);
  endtask

  initial begin
    reset = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
    read_reg1 = 5'd29; read_reg2 = 5'd5;
    model_reset();
    #2;
    check("rst_sp", read_data1, 32'd227);
    check("rst_r5", read_data2, 32'd0);
    read_reg1 = 5'd0; read_reg2 = 5'd31;
    #1;
    check("rst_r0", read_data1, 32'd0);
    check("rst_r31", read_data2, 32'd0);

    tbl[0] = '{1'b1, 5'd8,  32'hDEAD_BEEF, 5'd8,  5'd9,  32'hDEAD_BEEF, 32'd0};
    tbl[1] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd8,  32'd0,         32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 5'd12, 32'h0000_1234, 5'd12, 5'd29, 32'd0,         32'd227};
    tbl[3] = '{1'b0, 5'd12, 32'h0000_1234, 5'd12, 5'd12, 32'd0,         32'd0};
    tbl[4] = '{1'b0, 5'd12, 32'h0000_1234, 5'd12, 5'd8,  32'd0,         32'hDEAD_BEEF};
    tbl[5] = '{1'b1, 5'd3,  32'h0000_0001, 5'd3,  5'd8,  32'd1,         32'hDEAD_BEEF};
    tbl[6] = '{1'b1, 5'd8,  32'h8000_0000, 5'd8,  5'd3,  32'h8000_0000, 32'd1};

    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      reg_write = tbl[i].rw; write_reg = tbl[i].wr; write_data = tbl[i].wd;
      read_reg1 = tbl[i].r1; read_reg2 = tbl[i].r2;
      edge_update();
      check($sformatf("tbl%0d_p1", i), read_data1, tbl[i].e1);
      check($sformatf("tbl%0d_p2", i), read_data2, tbl[i].e2);
    end

    // No bypass: a same-cycle read of the written register sees the old value.
    @(negedge clk);
    reg_write = 1'b1; write_reg = 5'd31; write_data = 32'h40; read_reg2 = 5'd31;
    #1;
    check("byp_pre", read_data2, 32'd0);
    edge_update();
    check("byp_post", read_data2, 32'h40);

    @(negedge clk);
    write_reg = 5'd29; write_data = 32'h100; read_reg1 = 5'd29;
    edge_update();
    check("sp_write", read_data1, 32'h100);

    // Reset asserted between edges, with a write pending on the edge under reset.
    @(negedge clk);
    write_reg = 5'd29; write_data = 32'h555; read_reg2 = 5'd8;
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async_sp", read_data1, 32'd227);
    check("async_r8", read_data2, 32'd0);
    edge_update();
    check("rst_dom_sp", read_data1, 32'd227);
    @(negedge clk);
    reset = 1'b0;
    write_reg = 5'd5; write_data = 32'h0000_00A5; read_reg1 = 5'd5; read_reg2 = 5'd31;
    #1;
    check("first_pre", read_data1, 32'd0);
    edge_update();
    check("first_wr", read_data1, 32'h0000_00A5);
    check("r31_cleared", read_data2, 32'd0);

    // Unknown write index with write disabled must not touch any register.
    @(negedge clk);
    reg_write = 1'b0; write_reg = 'x; write_data = 32'hCAFE_F00D;
    edge_update();
    edge_update();
    write_reg = '0;

    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      reg_write  = 1'($urandom);
      write_reg  = 5'($urandom_range(31, 0));
      write_data = $urandom;
      read_reg1  = ($urandom_range(3, 0) == 0) ? write_reg : 5'($urandom);
      read_reg2  = ($urandom_range(3, 0) == 0) ? write_reg : 5'($urandom);
      #1;
      check_model($sformatf("rnd%0d_pre", n));
      edge_update();
      check_model($sformatf("rnd%0d_post", n));
    end

    @(negedge clk);
    reg_write = 1'b0;
    for (int i = 0; i < 32; i++) begin
      read_reg1 = 5'(i); read_reg2 = 5'(31 - i);
      #1;
      check_model($sformatf("sweep%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
